// File: rtl/ctr7_interval_sched_if.sv
// rtl/ctr7_interval_sched_if.sv - request/grant and counter-control bundle for ctr7_interval_sched
//
// Purpose: groups the requester handshake and the CTR7 counter control/readback
// signals of ctr7_interval_sched so they travel as one port.
//
// Signals:
//   REQ_0, REQ_1   requester delay requests (level, held until DONE or cancel)
//   LEN_0, LEN_1   requester delay lengths, 7 bits
//   GNT_0, GNT_1   counter ownership flags
//   DONE_0, DONE_1 one-cycle completion pulses
//   BUSY           scheduler not idle
//   CTR_D          counter load value
//   CTR_LDL        counter load, active low
//   CTR_ENAB       counter count enable
//   CTR_QL         counter inverted count readback (7'h7F means count 0)
//
// Modports:
//   master  requesters plus counter (drive REQ/LEN/CTR_QL)
//   slave   the scheduler (drives grants, completions and counter control)

interface ctr7_interval_sched_if;
   logic       REQ_0;
   logic [6:0] LEN_0;
   logic       REQ_1;
   logic [6:0] LEN_1;
   logic       GNT_0;
   logic       GNT_1;
   logic       DONE_0;
   logic       DONE_1;
   logic       BUSY;
   logic [6:0] CTR_D;
   logic       CTR_LDL;
   logic       CTR_ENAB;
   logic [6:0] CTR_QL;

   modport master (
      output REQ_0, LEN_0, REQ_1, LEN_1, CTR_QL,
      input  GNT_0, GNT_1, DONE_0, DONE_1, BUSY, CTR_D, CTR_LDL, CTR_ENAB
   );

   modport slave (
      input  REQ_0, LEN_0, REQ_1, LEN_1, CTR_QL,
      output GNT_0, GNT_1, DONE_0, DONE_1, BUSY, CTR_D, CTR_LDL, CTR_ENAB
   );
endinterface

// File: rtl/ctr7_interval_sched.sv
// rtl/ctr7_interval_sched.sv - two-requester interval scheduler sharing one CTR7 down-counter
//
// Purpose: arbitrates two delay requests, loads the shared 7-bit down-counter
// with the winner's length, enables counting until the count reaches zero and
// then pulses DONE to the winner. Every output is a register; nothing on REQ or
// LEN reaches an output without passing through a flop.
//
// Parameters:
//   RR      1 = round-robin on ties, 0 = fixed priority (requester 0 wins ties)
//
// Ports:
//   XCK     system clock, rising edge
//   RESETL  asynchronous active-low reset
//   bus     ctr7_interval_sched_if.slave (requests, grants, completions,
//           counter D/LDL/ENAB outputs, counter QL readback)

module ctr7_interval_sched #(
   parameter int RR = 1
) (
   input  logic                        XCK,
   input  logic                        RESETL,
   ctr7_interval_sched_if.slave        bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // QL is the inverted count: all ones is count 0, 7'h7E is count 1.
   localparam logic [6:0] QL_ZERO = 7'h7F;
   localparam logic [6:0] QL_ONE  = 7'h7E;

   state_t     state, state_n;
   logic       gnt_0, gnt_0_n;
   logic       gnt_1, gnt_1_n;
   logic       done_0, done_0_n;
   logic       done_1, done_1_n;
   logic       busy, busy_n;
   logic [6:0] ctr_d, ctr_d_n;
   logic       ctr_ldl, ctr_ldl_n;
   logic       ctr_enab, ctr_enab_n;
   logic       last, last_n;       // last winner: 0 or 1
   logic       pick_1;             // arbitration result in IDLE
   logic       owner_req;          // REQ of the current owner

   always_ff @(posedge XCK or negedge RESETL) begin
      if (!RESETL) begin
         state    <= ST_IDLE;
         gnt_0    <= 1'b0;
         gnt_1    <= 1'b0;
         done_0   <= 1'b0;
         done_1   <= 1'b0;
         busy     <= 1'b0;
         ctr_d    <= 7'h00;
         ctr_ldl  <= 1'b1;
         ctr_enab <= 1'b0;
         last     <= 1'b1;         // requester 0 wins the first tie
      end else begin
         state    <= state_n;
         gnt_0    <= gnt_0_n;
         gnt_1    <= gnt_1_n;
         done_0   <= done_0_n;
         done_1   <= done_1_n;
         busy     <= busy_n;
         ctr_d    <= ctr_d_n;
         ctr_ldl  <= ctr_ldl_n;
         ctr_enab <= ctr_enab_n;
         last     <= last_n;
      end
   end

   always_comb begin
      state_n    = state;
      gnt_0_n    = gnt_0;
      gnt_1_n    = gnt_1;
      done_0_n   = 1'b0;
      done_1_n   = 1'b0;
      ctr_d_n    = ctr_d;
      ctr_ldl_n  = 1'b1;
      ctr_enab_n = ctr_enab;
      last_n     = last;
      pick_1     = 1'b0;
      owner_req  = gnt_1 ? bus.REQ_1 : bus.REQ_0;

      case (state)
         ST_IDLE: begin
            ctr_enab_n = 1'b0;
            if (bus.REQ_0 || bus.REQ_1) begin
               if (bus.REQ_0 && bus.REQ_1)
                  pick_1 = (RR != 0) ? ~last : 1'b0;
               else
                  pick_1 = bus.REQ_1;
               state_n   = ST_LOAD;
               gnt_0_n   = ~pick_1;
               gnt_1_n   = pick_1;
               ctr_d_n   = pick_1 ? bus.LEN_1 : bus.LEN_0;
               ctr_ldl_n = 1'b0;
               last_n    = pick_1;
            end
         end

         ST_LOAD: begin
            if (!owner_req) begin
               state_n    = ST_IDLE;
               gnt_0_n    = 1'b0;
               gnt_1_n    = 1'b0;
               ctr_enab_n = 1'b0;
            end else begin
               // The counter takes ctr_d on this edge; a zero length never counts.
               state_n    = ST_RUN;
               ctr_enab_n = (ctr_d != 7'h00);
            end
         end

         ST_RUN: begin
            if (!owner_req) begin
               state_n    = ST_IDLE;
               gnt_0_n    = 1'b0;
               gnt_1_n    = 1'b0;
               ctr_enab_n = 1'b0;
            end else if (bus.CTR_QL == QL_ZERO) begin
               state_n    = ST_DONE;
               ctr_enab_n = 1'b0;
               done_0_n   = gnt_0;
               done_1_n   = gnt_1;
            end else if (ctr_enab) begin
               // Enable is registered, so it must drop on the same edge that
               // takes the count from 1 to 0; otherwise the following edge
               // (the one that sees zero) would decrement once more and wrap.
               ctr_enab_n = (bus.CTR_QL != QL_ONE);
            end else begin
               ctr_enab_n = 1'b1;
            end
         end

         ST_DONE: begin
            state_n    = ST_IDLE;
            gnt_0_n    = 1'b0;
            gnt_1_n    = 1'b0;
            ctr_enab_n = 1'b0;
         end

         default: begin
            state_n    = ST_IDLE;
            gnt_0_n    = 1'b0;
            gnt_1_n    = 1'b0;
            ctr_enab_n = 1'b0;
         end
      endcase

      busy_n = (state_n != ST_IDLE);
   end

   assign bus.GNT_0    = gnt_0;
   assign bus.GNT_1    = gnt_1;
   assign bus.DONE_0   = done_0;
   assign bus.DONE_1   = done_1;
   assign bus.BUSY     = busy;
   assign bus.CTR_D    = ctr_d;
   assign bus.CTR_LDL  = ctr_ldl;
   assign bus.CTR_ENAB = ctr_enab;

endmodule
